// File: rtl/des_key_schedule.sv
// des_key_schedule
// Sequential DES key-schedule generator. PC-1 is applied once when a start
// is accepted. The 16 round keys are then presented one per accepted cycle,
// either K1..K16 (encrypt) or K16..K1 (decrypt).
//
// Ports:
//   i_clk      - system clock, rising edge
//   i_rst      - synchronous active-high reset
//   i_start    - start request (accepted in IDLE, or on the last-key accept)
//   i_key      - 64-bit DES key, i_key[63] is DES bit 1
//   i_decrypt  - order select latched with the start (1 = K16..K1)
//   i_ready    - downstream accepts o_rd_key this cycle
//   o_kv       - o_rd_key valid
//   o_rd_key   - 48-bit round key, PC-2 bit 1 at [47]
//   o_round    - index of the presented key (0..15 = K1..K16)
//   o_busy     - schedule in progress
//   o_par_err  - last accepted key had a byte with even parity
module des_key_schedule #(
    parameter logic [15:0] SHIFT_MAP    = 16'h8103,
    parameter bit          PARITY_CHECK = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [63:0] i_key,
    input  logic        i_decrypt,
    input  logic        i_ready,
    output logic        o_kv,
    output logic [47:0] o_rd_key,
    output logic [3:0]  o_round,
    output logic        o_busy,
    output logic        o_par_err
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    // PC-1: DES input bit number (1 = MSB) for each of the 56 output bits.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: C/D bit number (1 = MSB of C) for each of the 48 key bits.
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  s_q, s_d;
    logic [3:0]  round_q, round_d;
    logic [47:0] key_q, key_d;
    logic        mode_q, mode_d;
    logic        par_q, par_d;

    logic [55:0] pc1_w;
    logic [55:0] cd_next;
    logic [47:0] pc2_w;
    logic [7:0]  byte_bad;
    logic        par_w;
    logic        load_key;
    logic        kv, accept, last_acc, start_acc;
    logic [3:0]  s_inc, s_rev;

    function automatic logic [27:0] rot_l(input logic [27:0] x, input logic by1);
        return by1 ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rot_r(input logic [27:0] x, input logic by1);
        return by1 ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 56; gi++) begin : g_pc1
            assign pc1_w[55-gi] = i_key[64-PC1_TAB[gi]];
        end
        // PC-2 is applied to the next C/D value so the key register is
        // loaded in the same edge as the rotation.
        for (gi = 0; gi < 48; gi++) begin : g_pc2
            assign pc2_w[47-gi] = cd_next[56-PC2_TAB[gi]];
        end
        for (gi = 0; gi < 8; gi++) begin : g_par
            assign byte_bad[gi] = ~(^i_key[8*gi +: 8]);
        end
        if (PARITY_CHECK) begin : g_par_on
            assign par_w = |byte_bad;
        end else begin : g_par_off
            assign par_w = 1'b0;
        end
    endgenerate

    assign kv        = (state_q == ST_RUN);
    assign accept    = kv & i_ready;
    assign last_acc  = accept & (s_q == 4'd15);
    assign start_acc = i_start & (~kv | last_acc);
    assign s_inc     = s_q + 4'd1;
    assign s_rev     = 4'd15 - s_q;

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        d_d      = d_q;
        s_d      = s_q;
        round_d  = round_q;
        mode_d   = mode_q;
        par_d    = par_q;
        load_key = 1'b0;
        if (start_acc) begin
            state_d  = ST_RUN;
            s_d      = 4'd0;
            mode_d   = i_decrypt;
            par_d    = par_w;
            load_key = 1'b1;
            if (i_decrypt) begin
                // C16/D16 equal C0/D0 since the total rotation is 28.
                c_d     = pc1_w[55:28];
                d_d     = pc1_w[27:0];
                round_d = 4'd15;
            end else begin
                c_d     = rot_l(pc1_w[55:28], SHIFT_MAP[0]);
                d_d     = rot_l(pc1_w[27:0], SHIFT_MAP[0]);
                round_d = 4'd0;
            end
        end else if (last_acc) begin
            // Key and round registers keep their last value.
            state_d = ST_IDLE;
        end else if (accept) begin
            s_d      = s_inc;
            load_key = 1'b1;
            if (mode_q) begin
                // Undo the rotation of round 16-s to step back one key.
                c_d     = rot_r(c_q, SHIFT_MAP[s_rev]);
                d_d     = rot_r(d_q, SHIFT_MAP[s_rev]);
                round_d = 4'd14 - s_q;
            end else begin
                c_d     = rot_l(c_q, SHIFT_MAP[s_inc]);
                d_d     = rot_l(d_q, SHIFT_MAP[s_inc]);
                round_d = s_inc;
            end
        end
    end

    assign cd_next = {c_d, d_d};

    always_comb begin
        key_d = key_q;
        if (load_key) begin
            key_d = pc2_w;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            s_q     <= '0;
            round_q <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            s_q     <= s_d;
            round_q <= round_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            par_q   <= par_d;
        end
    end

    assign o_kv      = kv;
    assign o_busy    = kv;
    assign o_rd_key  = key_q;
    assign o_round   = round_q;
    assign o_par_err = par_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule
// Directed bench for des_key_schedule. A reference schedule (cumulative
// rotation of C0/D0 per the FIPS shift list) is pushed to a queue on every
// start the bench expects to be accepted, and popped as keys are accepted.
module tb_des_key_schedule;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [63:0] i_key;
    logic        i_decrypt;
    logic        i_ready;
    logic        o_kv;
    logic [47:0] o_rd_key;
    logic [3:0]  o_round;
    logic        o_busy;
    logic        o_par_err;

    des_key_schedule dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_key     (i_key),
        .i_decrypt (i_decrypt),
        .i_ready   (i_ready),
        .o_kv      (o_kv),
        .o_rd_key  (o_rd_key),
        .o_round   (o_round),
        .o_busy    (o_busy),
        .o_par_err (o_par_err)
    );

    always #5 i_clk = ~i_clk;

    localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;
    localparam logic [63:0] KEY_J   = 64'h0123456789ABCDEF;
    localparam logic [47:0] K1_A    = 48'h1B02EFFC7072;
    localparam logic [47:0] K16_A   = 48'hCB3D8B0E17F5;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct packed {
        logic [3:0]  rnd;
        logic [47:0] key;
    } exp_t;

    exp_t        sb_q[$];
    logic [47:0] hold_key = '0;
    logic [3:0]  hold_rnd = '0;
    logic        exp_par  = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        logic [55:0] w;
        w = {x, x} << n;
        return w[55:28];
    endfunction

    task automatic push_sched(input logic [63:0] key, input logic dec);
        logic [55:0] cd, cdr;
        logic [47:0] ks [16];
        logic [47:0] k;
        logic        bad;
        int          cum;
        exp_t        e;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
        cum = 0;
        for (int r = 0; r < 16; r++) begin
            cum += SHIFTS[r];
            cdr = {rotl28(cd[55:28], cum), rotl28(cd[27:0], cum)};
            for (int j = 0; j < 48; j++) k[47-j] = cdr[56-PC2[j]];
            ks[r] = k;
        end
        for (int r = 0; r < 16; r++) begin
            e.rnd = dec ? 4'(15 - r) : 4'(r);
            e.key = ks[e.rnd];
            sb_q.push_back(e);
        end
        bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if ($countones(key[8*b +: 8]) % 2 == 0) bad = 1'b1;
        end
        exp_par = bad;
    endtask

    // Check the outputs of the current cycle, advance the model by one
    // edge, then wait for the next falling edge.
    task automatic tick();
        logic idle, last;
        chk("kv", 64'(o_kv), 64'(sb_q.size() != 0));
        chk("busy", 64'(o_busy), 64'(sb_q.size() != 0));
        chk("par_err", 64'(o_par_err), 64'(exp_par));
        if (sb_q.size() != 0) begin
            chk("key", 64'(o_rd_key), 64'(sb_q[0].key));
            chk("round", 64'(o_round), 64'(sb_q[0].rnd));
        end else begin
            chk("idle_key", 64'(o_rd_key), 64'(hold_key));
            chk("idle_round", 64'(o_round), 64'(hold_rnd));
        end
        if (i_rst) begin
            sb_q.delete();
            hold_key = '0;
            hold_rnd = '0;
            exp_par  = 1'b0;
        end else begin
            idle = (sb_q.size() == 0);
            last = (sb_q.size() == 1) && i_ready;
            if (!idle && i_ready) begin
                $display("accept round=%0d key=%h", sb_q[0].rnd, sb_q[0].key);
                hold_key = sb_q[0].key;
                hold_rnd = sb_q[0].rnd;
                void'(sb_q.pop_front());
            end
            if (i_start && (idle || last)) begin
                $display("start key=%h decrypt=%0b", i_key, i_decrypt);
                push_sched(i_key, i_decrypt);
            end
        end
        @(negedge i_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int last_stall;
        i_rst = 1'b1; i_start = 1'b0; i_key = '0; i_decrypt = 1'b0; i_ready = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        tick();
        i_rst = 1'b0;
        chk("reset_kv", 64'(o_kv), 64'd0);
        chk("reset_key", 64'(o_rd_key), 64'd0);
        tick();

        // Encrypt, no stalls.
        i_start = 1'b1; i_key = KEY_A; i_decrypt = 1'b0;
        tick();
        i_start = 1'b0;
        chk("enc_K1", 64'(o_rd_key), 64'(K1_A));
        repeat (15) tick();
        chk("enc_K16", 64'(o_rd_key), 64'(K16_A));
        chk("enc_K16_round", 64'(o_round), 64'd15);
        tick();
        chk("enc_done_kv", 64'(o_kv), 64'd0);
        chk("enc_par", 64'(o_par_err), 64'd0);
        tick();

        // Decrypt, no stalls.
        i_start = 1'b1; i_decrypt = 1'b1;
        tick();
        i_start = 1'b0;
        chk("dec_first", 64'(o_rd_key), 64'(K16_A));
        chk("dec_first_round", 64'(o_round), 64'd15);
        repeat (15) tick();
        chk("dec_last", 64'(o_rd_key), 64'(K1_A));
        chk("dec_last_round", 64'(o_round), 64'd0);
        tick();
        tick();

        // Random stalls, forced on the first and last key.
        i_start = 1'b1; i_decrypt = 1'b0; i_ready = 1'b0;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        g = 0;
        last_stall = 0;
        while (sb_q.size() != 0 && g < 400) begin
            if (sb_q.size() == 1 && last_stall < 2) begin
                i_ready = 1'b0;
                last_stall++;
            end else begin
                i_ready = 1'($urandom_range(0, 1));
            end
            tick();
            g++;
        end
        chk("stall_drain", 64'(sb_q.size()), 64'd0);
        i_ready = 1'b1;
        tick();

        // Back-to-back: start held high; junk key mid-run must be ignored,
        // a bad-parity decrypt key arrives on the last-accept cycle.
        i_start = 1'b1; i_key = KEY_A; i_decrypt = 1'b0;
        tick();
        i_key = KEY_J; i_decrypt = 1'b1;
        g = 0;
        while (sb_q.size() > 1 && g < 40) begin
            tick();
            g++;
        end
        chk("b2b_reach_last", 64'(sb_q.size()), 64'd1);
        i_key = KEY_BAD;
        tick();
        i_start = 1'b0;
        chk("b2b_kv", 64'(o_kv), 64'd1);
        chk("b2b_first", 64'(o_rd_key), 64'(K16_A));
        chk("bad_par", 64'(o_par_err), 64'd1);
        g = 0;
        while (sb_q.size() != 0 && g < 40) begin
            tick();
            g++;
        end
        chk("b2b_drain", 64'(sb_q.size()), 64'd0);
        chk("par_held", 64'(o_par_err), 64'd1);

        // Valid key clears the parity flag.
        i_start = 1'b1; i_key = KEY_A; i_decrypt = 1'b0;
        tick();
        i_start = 1'b0;
        chk("par_clear", 64'(o_par_err), 64'd0);

        // Reset mid-schedule at step 7, then a fresh run.
        repeat (6) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("rst_kv", 64'(o_kv), 64'd0);
        chk("rst_key", 64'(o_rd_key), 64'd0);
        chk("rst_round", 64'(o_round), 64'd0);
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("rst_K1", 64'(o_rd_key), 64'(K1_A));
        g = 0;
        while (sb_q.size() != 0 && g < 40) begin
            tick();
            g++;
        end
        chk("rst_drain", 64'(sb_q.size()), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Sequential DES key-schedule generator that replaces per-round instantiation of single-round key logic. It applies PC-1 to a 64-bit key once, then emits all 16 48-bit round keys, one per accepted cycle, in encrypt order (K1..K16) or decrypt order (K16..K1). Output uses a valid/ready handshake, so a downstream iterative or pipelined Feistel core can stall it. An optional key-parity check flags malformed keys.

## Interface
Parameters:
- SHIFT_MAP, 16'h8103: bit r set means round r+1 rotates left by 1; bit r clear means it rotates by 2. The default is the FIPS 46-3 schedule.
- PARITY_CHECK, 1: when 1, the block computes o_par_err; when 0, o_par_err ties to 0.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  start request; sampled per the acceptance rule below.
- i_key  input  64  DES key; i_key[63] is DES bit 1, i_key[0] is DES bit 64.
- i_decrypt  input  1  mode select sampled with the accepted start: 0 = K1→K16, 1 = K16→K1.
- i_ready  input  1  downstream accepts o_rd_key this cycle.
- o_kv  output  1  o_rd_key is valid.
- o_rd_key  output  48  round key; PC-2 output bit 1 is at [47].
- o_round  output  4  index of the key presented; 0..15 means K1..K16 (K16 = 15 in decrypt round 1).
- o_busy  output  1  a schedule is in progress (state RUN).
- o_par_err  output  1  at least one key byte of the last accepted key had even parity.

## Operation
- States: IDLE and RUN.
- Start acceptance: i_start is accepted when the state is IDLE, or in RUN on the cycle the last key is accepted (o_kv & i_ready & step==15). The accepted-on-last-key case gives back-to-back schedules. i_start is ignored in RUN at any other time.
- On an accepted start:
  - PC-1(i_key) splits into C0 (upper 28 bits) and D0.
  - Encrypt: C/D registers load C0/D0 rotated left by SHIFT_MAP[0]'s amount. The key register loads PC-2 of that rotated value (K1). o_round = 0.
  - Decrypt: C/D registers load C0/D0 unrotated (C16 = C0). The key register loads PC-2(C0,D0) = K16. o_round = 15.
  - i_decrypt is latched into a mode register. o_par_err is updated.
- Internal step counter s runs 0..15. Each accept (o_kv & i_ready) with s<15 increments s and advances C/D:
  - Encrypt: rotate left by the amount for round s+2, i.e. SHIFT_MAP[s+1]. o_round = s+1.
  - Decrypt: rotate right by the amount for round 16-s, i.e. SHIFT_MAP[15-s]. o_round = 14-s.
  - The key register loads PC-2 of the new C/D.
- Accept with s==15 and no new start: state → IDLE, o_kv → 0. o_rd_key holds its last value.
- Stall (o_kv & !i_ready): C, D, s, o_rd_key and o_round all hold.
- Total rotation over 16 rounds is 28, so C/D return to C0/D0. No separate key storage is needed.
- Parity: each byte i_key[8k+7:8k] must contain an odd number of ones. o_par_err is the OR of the per-byte failures, registered at accepted start and held until the next accepted start. The schedule runs regardless of the flag.

## Timing
- Reset values: state IDLE, o_kv=0, o_busy=0, o_rd_key=0, o_round=0, o_par_err=0, C/D=0, s=0.
- i_rst dominates every other input. Reset mid-schedule aborts the run and the next cycle shows reset values.
- Latency: start accepted at edge T gives o_kv=1 with the first key from cycle T+1.
- Throughput is one key per cycle when i_ready=1. With no stalls the 16 keys occupy cycles T+1..T+16.
- o_busy equals o_kv; both are 1 throughout RUN, including stalled cycles.
- Back-to-back start: the new first key appears the cycle after the last old key is accepted, with no bubble. o_par_err and the mode register update on that edge.
- All outputs are registered. No combinational path exists from i_ready or i_start to any output.

## Test plan
- Encrypt, i_key=64'h133457799BBCDFF1, i_ready=1 → K1=48'h1B02EFFC7072 at cycle T+1; K16=48'hCB3D8B0E17F5 at T+16 with o_round=15; o_kv=0 at T+17; o_par_err=0.
- Decrypt, same key → first key 48'hCB3D8B0E17F5 with o_round=15; last key 48'h1B02EFFC7072 with o_round=0. The full sequence is the exact reverse of the encrypt run.
- Random i_ready stalls, including stalls on the first and last key → key sequence identical to the unstalled run; o_rd_key and o_round stable whenever o_kv & !i_ready.
- i_start held high across a run, with a second key presented on the last-accept cycle → 32 consecutive valid keys; the second schedule uses the second key and mode. Starts at other RUN cycles are ignored.
- i_key=64'h133457799BBCDFF0 → o_par_err=1 (the LSB byte has even parity) and the schedule is still produced. The next start with a valid key clears the flag.
- Assert i_rst at step 7 → next cycle o_kv=0, o_rd_key=0, o_round=0. A fresh start then produces the full 16-key sequence from K1.
